subtree_rr_scheduler: RTL and testbench
=======================================

# subtree_rr_scheduler

Round-robin scheduler that shares one downstream resource among the five sibling leaf instances of a generated subtree node (children 0..4). Each child raises a request, receives an exclusive one-hot grant, and releases it with a done pulse. An optional watchdog reclaims the grant from a child that never signals done. The block sits at the subtree node level, between the children and the shared resource.

## Interface
- `N_REQ`, default 5: number of requesters; one per child instance, index = child number.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in BUSY cycles; must be ≥ 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_i` in N_REQ: level request per child.
- `done_i` in N_REQ: release pulse per child; only the bit of the current grantee is honoured.
- `grant_o` out N_REQ: one-hot grant, or all zero.
- `grant_id_o` out $clog2(N_REQ): index of the current grantee; holds the last grantee while idle.
- `busy_o` out 1: high while any grant is active.
- `timeout_o` out 1: one-cycle pulse when the watchdog reclaims a grant.

## Operation
- FSM has two states: IDLE and BUSY.
- **IDLE**
  - If `req_i` ≠ 0, select the first set bit scanning from `ptr` upward with wrap-around.
  - Register the grant and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `grant_o` is held constant.
  - If `done_i[grant_id_o]`=1, go to IDLE.
  - `done_i` bits of non-granted children are ignored.
  - Dropping `req_i` of the grantee does not release the grant; only done or timeout releases it.
- **Pointer**
  - `ptr` updates when a grant is issued: ptr = (granted index + 1) mod N_REQ.
  - Result: the grantee becomes lowest priority. Any continuously requesting child is served within N_REQ grants.
- **Arithmetic**
  - `ptr` and `grant_id_o` are $clog2(N_REQ) bits.
  - Wrap is an explicit compare against N_REQ−1, not a power-of-two overflow.

## Timing
- **Reset values:** state IDLE, `ptr`=0, `grant_o`=0, `grant_id_o`=0, `busy_o`=0, `timeout_o`=0, watchdog counter 0.
- **Grant latency:** request seen in IDLE at cycle t gives `grant_o`/`busy_o` high at t+1.
- **Release:** `done_i` of the grantee high at cycle t gives `grant_o`=0 at t+1.
- **Bubble:** at least one IDLE cycle between consecutive grants. The next grant is visible at t+2 at the earliest.
- **Simultaneous requests in IDLE:** exactly one grant, chosen by `ptr` order.
- **`rst` asserted in BUSY:** the grant drops on the next edge with no timeout pulse, and `ptr` returns to 0.
- `done_i` of the grantee in the same cycle the grant is issued is not seen. `done_i` is sampled only from the first BUSY cycle onward.

## Configuration
- Macro: `SUBTREE_SCHED_TIMEOUT_EN`.
- **Defined:**
  - The counter clears on grant and increments each BUSY cycle without done.
  - When it reaches TIMEOUT_CYCLES−1 without done, the next edge does three things: clears the grant, returns the FSM to IDLE, and pulses `timeout_o` for exactly one cycle.
  - `ptr` is unaffected by a timeout; it already advanced at grant.
  - If done and the limit coincide, done wins and there is no pulse.
- **Undefined:**
  - No counter is built.
  - `timeout_o` is tied to 0.
  - BUSY waits indefinitely for done.

## Structure
- Package `subtree_sched_pkg`:
  - `sched_state_e` (IDLE, BUSY).
  - Default `N_REQ`/`TIMEOUT_CYCLES` localparams.
  - `idx_t` typedef.
- One sub-module, `rr_pick`:
  - Purely combinational: (req vector, ptr) → (valid, index, one-hot).
  - Reused by sibling nodes.
- Main module holds the FSM, the pointer, and the optional watchdog.

## Test plan
- **Reset then single request:** `req_i`=5'b00100 at cycle 3 → `grant_o`=5'b00100 and `grant_id_o`=2 at cycle 4; `done_i[2]` at cycle 6 → `grant_o`=0 at cycle 7.
- **Fairness:** `req_i`=5'b11111 held, each grantee sends done one cycle after its grant → grant order 0,1,2,3,4,0. Each grant is separated by one idle cycle.
- **Wrap:**
  - After a grant to child 4, `req_i`=5'b00011 → grant to 0.
  - Then grant to 1.
- **Foreign done ignored:** child 1 granted, `done_i`=5'b00100 pulses → grant to 1 held; `busy_o` stays 1.
- **Watchdog (macro defined, TIMEOUT_CYCLES=8):**
  - Child 3 granted and never sends done → `timeout_o` pulses exactly once, 8 cycles after the grant rose, with `grant_o`=0 on the same edge.
  - A pending `req_i[4]` is granted one cycle later.
- **Mid-BUSY reset:** `rst` pulsed during a grant to child 2 → all outputs return to reset values next edge. With `req_i`=5'b00110 afterwards, child 1 is granted first, because `ptr`=0.

Source files
------------

// File: rtl/subtree_rr_scheduler_pkg.sv
// +--------------------------------------------------------------------+
// | subtree_sched_pkg: shared types and defaults for the subtree        |
// | round-robin scheduler.  Rev 1.0                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package subtree_sched_pkg;

   localparam int N_REQ_DEF          = 5;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } sched_state_e;

   // Index width that stays legal for a single-requester build.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [idx_width(N_REQ_DEF)-1:0] idx_t;

endpackage

`default_nettype wire

// File: rtl/subtree_rr_scheduler_if.sv
// +--------------------------------------------------------------------+
// | subtree_rr_scheduler_if: request/done/grant bundle between the      |
// | children of a subtree node and its scheduler.  Rev 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

interface subtree_rr_scheduler_if
   import subtree_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
);
   localparam int ID_W = idx_width(N_REQ);

   logic [N_REQ-1:0] req_i;
   logic [N_REQ-1:0] done_i;
   logic [N_REQ-1:0] grant_o;
   logic [ID_W-1:0]  grant_id_o;
   logic             busy_o;
   logic             timeout_o;

   modport master (
      input  req_i,
      input  done_i,
      output grant_o,
      output grant_id_o,
      output busy_o,
      output timeout_o
   );

   modport slave (
      output req_i,
      output done_i,
      input  grant_o,
      input  grant_id_o,
      input  busy_o,
      input  timeout_o
   );
endinterface

`default_nettype wire

// File: rtl/subtree_rr_scheduler_rr_pick.sv
// +--------------------------------------------------------------------+
// | rr_pick: combinational round-robin selector, first set request at   |
// | or above ptr with wrap-around.  Rev 1.0                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_pick
   import subtree_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int ID_W  = idx_width(N_REQ)
)(
   input  wire logic [N_REQ-1:0] i_req,
   input  wire logic [ID_W-1:0]  i_ptr,
   output logic                  o_valid,
   output logic [ID_W-1:0]       o_idx,
   output logic [N_REQ-1:0]      o_onehot
);

   logic [ID_W-1:0] w_cand;

   // Walk N_REQ candidates from ptr; wrap is an explicit compare since
   // N_REQ need not be a power of two.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = i_ptr;
      for (int i = 0; i < N_REQ; i++) begin
         if (!o_valid && i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
         w_cand = (w_cand == ID_W'(N_REQ - 1)) ? '0 : w_cand + ID_W'(1);
      end
   end

   assign o_onehot = o_valid ? (N_REQ'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/subtree_rr_scheduler.sv
// +--------------------------------------------------------------------+
// | subtree_rr_scheduler: IDLE/BUSY round-robin grant of one shared     |
// | resource; optional watchdog via SUBTREE_SCHED_TIMEOUT_EN.  Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module subtree_rr_scheduler
   import subtree_sched_pkg::*;
#(
   parameter int N_REQ          = N_REQ_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input wire logic               clk,
   input wire logic               rst,
   subtree_rr_scheduler_if.master bus
);

   localparam int         ID_W   = idx_width(N_REQ);
   localparam logic [0:0] S_IDLE = 1'(IDLE);
   localparam logic [0:0] S_BUSY = 1'(BUSY);

   logic [0:0]       r_state;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  r_grant_id;
   logic [N_REQ-1:0] r_grant;

   logic             w_pick_valid;
   logic [ID_W-1:0]  w_pick_idx;
   logic [N_REQ-1:0] w_pick_onehot;
   logic             w_grant_issue;
   logic             w_done;
   logic             w_expire;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .i_req    (bus.req_i),
      .i_ptr    (r_ptr),
      .o_valid  (w_pick_valid),
      .o_idx    (w_pick_idx),
      .o_onehot (w_pick_onehot)
   );

   assign w_grant_issue = (r_state == S_IDLE) && w_pick_valid;
   assign w_done        = (r_state == S_BUSY) && bus.done_i[r_grant_id];

`ifdef SUBTREE_SCHED_TIMEOUT_EN
   localparam int WD_W = idx_width(TIMEOUT_CYCLES);

   logic [WD_W-1:0] r_wdog;
   logic            r_timeout;

   // Done on the limit cycle takes priority, so no reclaim then.
   assign w_expire = (r_state == S_BUSY) && !w_done &&
                     (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_grant_issue) begin
            r_wdog <= '0;
         end else if ((r_state == S_BUSY) && !w_done && !w_expire) begin
            r_wdog <= r_wdog + WD_W'(1);
         end
      end
   end

   assign bus.timeout_o = r_timeout;
`else
   assign w_expire      = 1'b0;
   assign bus.timeout_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_grant_id <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_issue) begin
                  r_grant    <= w_pick_onehot;
                  r_grant_id <= w_pick_idx;
                  r_ptr      <= (w_pick_idx == ID_W'(N_REQ - 1)) ? '0
                                                                 : w_pick_idx + ID_W'(1);
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               // grant_id is kept so it reports the last grantee while idle.
               if (w_done || w_expire) begin
                  r_grant <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.grant_o    = r_grant;
   assign bus.grant_id_o = r_grant_id;
   assign bus.busy_o     = (r_state == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_subtree_rr_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_subtree_rr_scheduler: directed and random checks of the          |
// | scheduler against a cycle-level behavioural model.  Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_subtree_rr_scheduler;
   import subtree_sched_pkg::*;

   localparam int N  = 5;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   subtree_rr_scheduler_if #(.N_REQ(N)) bus ();

   subtree_rr_scheduler #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: who holds the grant, the rotating start point,
   // and how long the current grant has been held.
   bit m_busy = 1'b0;
   int m_gid  = 0;
   int m_ptr  = 0;
   int m_age  = 0;
   bit m_to   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_pick(input int ptr, input logic [N-1:0] rq);
      for (int k = 0; k < N; k++) begin
         if (rq[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic void model_update(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
      int c;
      if (r) begin
         m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_age = 0; m_to = 1'b0;
         return;
      end
      m_to = 1'b0;
      if (!m_busy) begin
         c = model_pick(m_ptr, rq);
         if (c >= 0) begin
            m_busy = 1'b1; m_gid = c; m_ptr = (c + 1) % N; m_age = 0;
         end
      end else if (dn[m_gid]) begin
         m_busy = 1'b0;
      end else begin
`ifdef SUBTREE_SCHED_TIMEOUT_EN
         if (m_age == TO - 1) begin
            m_busy = 1'b0; m_to = 1'b1;
         end else begin
            m_age++;
         end
`endif
      end
   endfunction

   task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
      rst        = r;
      bus.req_i  = rq;
      bus.done_i = dn;
      @(posedge clk);
      model_update(r, rq, dn);
      #1;
      check_val("grant",    32'(bus.grant_o),    m_busy ? (32'd1 << m_gid) : 32'd0);
      check_val("grant_id", 32'(bus.grant_id_o), 32'(m_gid));
      check_val("busy",     32'(bus.busy_o),     32'(m_busy));
      check_val("timeout",  32'(bus.timeout_o),  32'(m_to));
   endtask

   int order [6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      logic [N-1:0] rq, dn;
      int gid;

      bus.req_i  = '0;
      bus.done_i = '0;

      // Reset, then a single request from child 2.
      step(1'b1, '0, '0);
      step(1'b1, '0, '0);
      check_val("rst_grant", 32'(bus.grant_o), 32'd0);
      step(1'b0, 5'b00100, '0);
      check_val("s1_grant", 32'(bus.grant_o), 32'b00100);
      check_val("s1_id",    32'(bus.grant_id_o), 32'd2);
      step(1'b0, '0, '0);
      step(1'b0, '0, 5'b00100);
      check_val("s1_release", 32'(bus.grant_o), 32'd0);

      // Fairness with everyone requesting.
      step(1'b1, '0, '0);
      for (int g = 0; g < 6; g++) begin
         step(1'b0, 5'b11111, '0);
         check_val("fair_order", 32'(bus.grant_id_o), 32'(order[g]));
         gid = int'(bus.grant_id_o);
         step(1'b0, 5'b11111, 5'(1 << gid));
         check_val("fair_bubble", 32'(bus.busy_o), 32'd0);
      end

      // Wrap from child 4 back to 0, then 1; foreign done ignored.
      step(1'b0, 5'b10000, '0);
      check_val("wrap_g4", 32'(bus.grant_o), 32'b10000);
      step(1'b0, '0, 5'b10000);
      step(1'b0, 5'b00011, '0);
      check_val("wrap_g0", 32'(bus.grant_o), 32'b00001);
      step(1'b0, 5'b00011, 5'b00001);
      step(1'b0, 5'b00011, '0);
      check_val("wrap_g1", 32'(bus.grant_o), 32'b00010);
      step(1'b0, 5'b00011, 5'b00100);
      check_val("foreign_grant", 32'(bus.grant_o), 32'b00010);
      check_val("foreign_busy",  32'(bus.busy_o), 32'd1);
      step(1'b0, '0, 5'b00010);

`ifdef SUBTREE_SCHED_TIMEOUT_EN
      // Child 3 never completes; child 4 waits behind it.
      step(1'b0, 5'b01000, '0);
      check_val("wd_g3", 32'(bus.grant_o), 32'b01000);
      for (int k = 1; k <= TO; k++) begin
         step(1'b0, 5'b11000, '0);
         check_val("wd_pulse", 32'(bus.timeout_o), (k == TO) ? 32'd1 : 32'd0);
         check_val("wd_grant", 32'(bus.grant_o), (k == TO) ? 32'd0 : 32'b01000);
      end
      step(1'b0, 5'b11000, '0);
      check_val("wd_next", 32'(bus.grant_o), 32'b10000);
      check_val("wd_once", 32'(bus.timeout_o), 32'd0);
      step(1'b0, '0, 5'b10000);
`endif

      // Reset while child 2 holds the grant.
      step(1'b1, '0, '0);
      step(1'b0, 5'b00100, '0);
      step(1'b1, 5'b00100, '0);
      check_val("mid_rst_grant", 32'(bus.grant_o), 32'd0);
      check_val("mid_rst_busy",  32'(bus.busy_o), 32'd0);
      check_val("mid_rst_id",    32'(bus.grant_id_o), 32'd0);
      step(1'b0, 5'b00110, '0);
      check_val("mid_rst_g1", 32'(bus.grant_o), 32'b00010);
      step(1'b0, '0, 5'b00010);

      // Random traffic: sparse requests, noisy done, rare resets.
      for (int i = 0; i < 1500; i++) begin
         rq = 5'($urandom) & 5'($urandom);
         dn = 5'($urandom) & 5'($urandom) & 5'($urandom);
         if ($urandom_range(0, 3) == 0) dn[m_gid] = 1'b1;
         step(($urandom_range(0, 199) == 0), rq, dn);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
